ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_if.sv | 47 ++++
 rtl/ex_mem_stage.sv | 100 ++++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline-register bundle: EX-side request fields, flush/stall control,
// and the registered MEM slot plus stall statistics driven back by the stage.
interface ex_mem_if #(
    parameter int AOP_W = 8,
    parameter int DW    = 32
);
    logic             flush_i;
    logic             mem_stall_i;
    logic             ex_valid_i;
    logic             ex_ok_i;
    logic [DW-1:0]    ex_pc_i;
    logic [AOP_W-1:0] ex_aluop_i;
    logic             ex_wreg_i;
    logic [4:0]       ex_waddr_i;
    logic [2*DW-1:0]  ex_wdata_i;
    logic             ex_whilo_i;
    logic [DW-1:0]    ex_store_data_i;

    logic             ex_stall_o;
    logic             mem_valid_o;
    logic [DW-1:0]    mem_pc_o;
    logic [AOP_W-1:0] mem_aluop_o;
    logic             mem_wreg_o;
    logic [4:0]       mem_waddr_o;
    logic [DW-1:0]    mem_wdata_o;
    logic [DW-1:0]    mem_hi_o;
    logic [DW-1:0]    mem_lo_o;
    logic             mem_whilo_o;
    logic [DW-1:0]    mem_store_data_o;
    logic [DW-1:0]    stall_cnt_o;

    modport master (
        output flush_i, mem_stall_i, ex_valid_i, ex_ok_i, ex_pc_i, ex_aluop_i,
               ex_wreg_i, ex_waddr_i, ex_wdata_i, ex_whilo_i, ex_store_data_i,
        input  ex_stall_o, mem_valid_o, mem_pc_o, mem_aluop_o, mem_wreg_o,
               mem_waddr_o, mem_wdata_o, mem_hi_o, mem_lo_o, mem_whilo_o,
               mem_store_data_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, mem_stall_i, ex_valid_i, ex_ok_i, ex_pc_i, ex_aluop_i,
               ex_wreg_i, ex_waddr_i, ex_wdata_i, ex_whilo_i, ex_store_data_i,
        output ex_stall_o, mem_valid_o, mem_pc_o, mem_aluop_o, mem_wreg_o,
               mem_waddr_o, mem_wdata_o, mem_hi_o, mem_lo_o, mem_whilo_o,
               mem_store_data_o, stall_cnt_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with multi-cycle-divide wait, MEM back-pressure hold,
// flush, HI/LO split and a saturating stall-cycle counter.
module ex_mem_stage #(
    parameter int AOP_W = 8,
    parameter int DW    = 32
) (
    input logic     clk_i,
    input logic     rst_i,
    ex_mem_if.slave bus
);
    typedef enum logic [1:0] {RUN, WAIT_EX, HOLD} state_t;

    state_t           state;
    logic             valid_q;
    logic             wreg_q;
    logic             whilo_q;
    logic [4:0]       waddr_q;
    logic [DW-1:0]    pc_q;
    logic [AOP_W-1:0] aluop_q;
    logic [DW-1:0]    hi_q;
    logic [DW-1:0]    lo_q;
    logic [DW-1:0]    store_q;
    logic [DW-1:0]    cnt_q;
    logic             stall;
    logic             take;
    logic             wait_div;

    // Flush and reset both override any stall request.
    always_comb begin
        stall = 1'b0;
        if (!rst_i && !bus.flush_i)
            stall = (bus.ex_valid_i && !bus.ex_ok_i) || bus.mem_stall_i;
    end

    assign take     = bus.ex_valid_i && bus.ex_ok_i;
    assign wait_div = bus.ex_valid_i && !bus.ex_ok_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= RUN;
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            whilo_q <= 1'b0;
            waddr_q <= '0;
            pc_q    <= '0;
            aluop_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            store_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (stall && cnt_q != '1)
                cnt_q <= cnt_q + DW'(1);

            if (bus.flush_i) begin
                valid_q <= 1'b0;
                wreg_q  <= 1'b0;
                whilo_q <= 1'b0;
                state   <= RUN;
            end else if (bus.mem_stall_i) begin
                // MEM slot frozen; EX keeps its entry, so nothing is lost.
                state <= HOLD;
            end else begin
                if (take) begin
                    valid_q <= 1'b1;
                    wreg_q  <= bus.ex_wreg_i;
                    whilo_q <= bus.ex_whilo_i;
                    waddr_q <= bus.ex_waddr_i;
                    pc_q    <= bus.ex_pc_i;
                    aluop_q <= bus.ex_aluop_i;
                    hi_q    <= bus.ex_wdata_i[2*DW-1:DW];
                    lo_q    <= bus.ex_wdata_i[DW-1:0];
                    store_q <= bus.ex_store_data_i;
                end else begin
                    valid_q <= 1'b0;
                    wreg_q  <= 1'b0;
                    whilo_q <= 1'b0;
                end
                unique case (state)
                    WAIT_EX: state <= wait_div ? WAIT_EX : RUN;
                    HOLD:    state <= wait_div ? WAIT_EX : RUN;
                    default: state <= wait_div ? WAIT_EX : RUN;
                endcase
            end
        end
    end

    assign bus.ex_stall_o       = stall;
    assign bus.mem_valid_o      = valid_q;
    assign bus.mem_wreg_o       = valid_q & wreg_q;
    assign bus.mem_whilo_o      = valid_q & whilo_q;
    assign bus.mem_waddr_o      = waddr_q;
    assign bus.mem_pc_o         = pc_q;
    assign bus.mem_aluop_o      = aluop_q;
    assign bus.mem_wdata_o      = lo_q;
    assign bus.mem_hi_o         = hi_q;
    assign bus.mem_lo_o         = lo_q;
    assign bus.mem_store_data_o = store_q;
    assign bus.stall_cnt_o      = cnt_q;
endmodule
